// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the chunked sequential adder.
// Holds the FSM encoding, default sizing and the chunk-index width helper.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 12;
  localparam int DEF_CHUNK = 3;

  // A one-chunk counter still needs one bit, so clamp the width at 1.
  function automatic int idx_width(input int nchunk);
    return (nchunk <= 2) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/adder_seq_if.sv
// Operand/result handshake bundle for adder_seq_ctrl.
// The master side is the producer/consumer; the slave side is the sequencer.
interface adder_seq_if #(
  parameter int WIDTH = adder_seq_pkg::DEF_WIDTH
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output start_valid, a, b, cin, res_ready,
    input  start_ready, res_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  start_valid, a, b, cin, res_ready,
    output start_ready, res_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
// The sequencer time-multiplexes this single slice across all chunks.
module chunk_adder #(
  parameter int CHUNK = adder_seq_pkg::DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencer adding two WIDTH-bit operands through one CHUNK-bit slice,
// one chunk per clock, LSB chunk first, with ready/valid on both sides.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic      clk,
  input  logic      rst_n,
  adder_seq_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);

  generate
    if ((WIDTH % CHUNK) != 0 || NCHUNK < 2) begin : g_bad_params
      $error("adder_seq_ctrl: WIDTH must be a multiple of CHUNK with at least two chunks");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [CHUNK-1:0] slice_a, slice_b, slice_s;
  logic             slice_cout;
  logic             accept, last_chunk, a_msb, b_msb;

  assign accept     = bus.start_valid && (state_q == IDLE);
  assign last_chunk = (idx_q == IW'(NCHUNK - 1));
  assign slice_a    = a_q[idx_q*CHUNK +: CHUNK];
  assign slice_b    = b_q[idx_q*CHUNK +: CHUNK];
  assign a_msb      = a_q[WIDTH-1];
  assign b_msb      = b_q[WIDTH-1];

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // NOTE: every always_comb output gets a default before any branch so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)                        state_d = RUN;
      RUN:     if (last_chunk)                    state_d = DONE;
      DONE:    if (bus.res_ready)                 state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: operands and carry load on accept; one chunk retires per RUN edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      carry_q <= bus.cin;
      sum_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[idx_q*CHUNK +: CHUNK] <= slice_s;
      carry_q                     <= slice_cout;
      if (last_chunk) begin
        idx_q  <= '0;
        cout_q <= slice_cout;
        // The top chunk's MSB is the new sum MSB.
        ovf_q  <= (a_msb ~^ b_msb) & (a_msb ^ slice_s[CHUNK-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.sum         = sum_q;
  assign bus.cout        = cout_q;
  assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl at default sizing (12-bit, 3-bit chunks).
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_adder_seq_ctrl;
  import adder_seq_pkg::*;

  localparam int W = 12;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  adder_seq_if #(.WIDTH(W)) bus ();

  adder_seq_ctrl #(.WIDTH(W), .CHUNK(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full accept -> result -> handshake cycle with latency and result checks.
  task automatic run_add(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    int waited;
    logic early;
    waited = 0;
    while (bus.start_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (bus.start_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: start_ready=%b required 1 within 20 cycles", name, bus.start_ready);
    end
    bus.a = av; bus.b = bv; bus.cin = ci; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble the operand ports; the op in flight must not see this.
    bus.start_valid = 1'b0; bus.a = ~av; bus.b = 12'h5A5; bus.cin = ~ci;
    total++;
    if (bus.busy !== 1'b1 || bus.start_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy: busy=%b start_ready=%b required 1/0", name, bus.busy, bus.start_ready);
    end
    early = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
      if (i < 4 && bus.res_valid !== 1'b0) early = 1'b1;
    end
    total++;
    if (early || bus.res_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_latency: res_valid=%b early=%b required 1 at accept+4", name, bus.res_valid, early);
    end
    total++;
    if (bus.sum !== es || bus.cout !== ec || bus.ovf !== eo) begin
      bad++;
      $display("FAIL %s_result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
               name, bus.sum, bus.cout, bus.ovf, es, ec, eo);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    total++;
    if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1 || bus.sum !== es) begin
      bad++;
      $display("FAIL %s_handshake: res_valid=%b start_ready=%b sum=%h required 0/1/%h",
               name, bus.res_valid, bus.start_ready, bus.sum, es);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.res_ready = 1'b0;
    #3;
    total++;
    if (bus.sum !== 12'h000 || bus.cout !== 1'b0 || bus.ovf !== 1'b0 ||
        bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.start_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: sum=%h cout=%b ovf=%b res_valid=%b busy=%b start_ready=%b required 000/0/0/0/0/1",
               bus.sum, bus.cout, bus.ovf, bus.res_valid, bus.busy, bus.start_ready);
    end
    // start_valid during reset must not capture anything.
    bus.start_valid = 1'b1; bus.a = 12'h321;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_capture: busy=%b required 0", bus.busy);
    end
    bus.start_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith();
    run_add("basic",     12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0);
    run_add("ripple",    12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    run_add("ovf_pos",   12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1);
    run_add("ovf_neg",   12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 1'b1);
    run_add("cin_only",  12'h000, 12'h000, 1'b1, 12'h001, 1'b0, 1'b0);
    run_add("mixed_cin", 12'hA5C, 12'h3B7, 1'b1, 12'hE14, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    bus.a = 12'h111; bus.b = 12'h222; bus.cin = 1'b0; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus.res_valid !== 1'b1 || bus.sum !== 12'h333) begin
      bad++;
      $display("FAIL bp_result: res_valid=%b sum=%h required 1/333", bus.res_valid, bus.sum);
    end
    bus.a = 12'h0F0; bus.b = 12'h00F; bus.cin = 1'b0; bus.start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.res_valid !== 1'b1 || bus.sum !== 12'h333 || bus.cout !== 1'b0 || bus.start_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: res_valid=%b sum=%h cout=%b start_ready=%b required 1/333/0/0",
                 i, bus.res_valid, bus.sum, bus.cout, bus.start_ready);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    total++;
    if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: start_ready=%b res_valid=%b required 1/0", bus.start_ready, bus.res_valid);
    end
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b1 || bus.sum !== 12'h000) begin
      bad++;
      $display("FAIL bp_accept: busy=%b sum=%h required 1/000", bus.busy, bus.sum);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    total++;
    if (bus.res_valid !== 1'b1 || bus.sum !== 12'h0FF || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL bp_second: res_valid=%b sum=%h cout=%b required 1/0FF/0", bus.res_valid, bus.sum, bus.cout);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bus.a = 12'h123; bus.b = 12'h456; bus.cin = 1'b0; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    // Two chunks done: low six bits of 0x579, upper chunks still zero.
    total++;
    if (bus.sum !== 12'h039 || bus.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL partial_sum: sum=%h res_valid=%b required 039/0", bus.sum, bus.res_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sum !== 12'h000) begin
      bad++;
      $display("FAIL reset_abort: res_valid=%b busy=%b sum=%h required 0/0/000",
               bus.res_valid, bus.busy, bus.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_add("after_reset", 12'h00A, 12'h005, 1'b0, 12'h00F, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencer that performs a WIDTH-bit add through one shared CHUNK-bit adder slice, one slice per clock, LSB chunk first.
- Holds a registered carry between slices and collects the partial sums into a result register.
- Ready/valid handshakes on the operand and result sides.
- Sits between operand producers and consumers where a full-width adder costs too much area.

Parameters:
WIDTH, 12, operand/result width in bits; WIDTH % CHUNK == 0 and WIDTH/CHUNK >= 2, else elaboration error
CHUNK, 3, slice width in bits; NCHUNK = WIDTH/CHUNK cycles per add

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start_valid  input  1  operand request
start_ready  output  1  high only in IDLE
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
cin  input  1  carry-in, sampled on accept
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  two's-complement overflow
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE. Reset state IDLE.
- Reset values: sum=0, cout=0, ovf=0, res_valid=0, busy=0, chunk index=0, carry reg=0, operand regs=0.
- start_ready = (state==IDLE); no capture occurs while rst_n is low.
- Accept edge: start_valid && start_ready at edge k.
  - Latch a, b into operand regs; latch cin into carry reg.
  - Clear sum; set idx=0; go to RUN.
- RUN, each edge:
  - Slice input is a_reg/b_reg chunk[idx] plus carry reg.
  - Slice sum is written into sum chunk[idx]; slice cout goes to carry reg; idx increments.
  - On the edge where idx==NCHUNK-1: go to DONE; cout = slice cout; ovf = a_reg[MSB] ~^ b_reg[MSB] & (a_reg[MSB] ^ new sum[MSB]); idx returns to 0.
- Latency: res_valid rises at edge k+NCHUNK (4 cycles at defaults).
- DONE:
  - res_valid=1; sum/cout/ovf held stable until the handshake.
  - res_valid && res_ready at an edge -> IDLE, res_valid=0, start_ready=1 in the next cycle.
  - sum/cout/ovf keep their value after the handshake until the next accept clears sum.
- No overlap. Throughput is one add per NCHUNK+2 cycles minimum. start_valid in RUN/DONE is ignored, with no capture.
- Operand port changes after accept have no effect on the operation in flight.
- sum bits outside the completed chunks read 0 during RUN; a consumer must use the result only when res_valid=1.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum.
- Async reset mid-RUN/DONE: abort immediately with all outputs to reset values; no result is produced for the aborted op.
- res_ready high in IDLE/RUN: no effect.

Decomposition:
- Package adder_seq_pkg:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH/CHUNK constants.
  - Function computing the index width, clog2(NCHUNK) with a minimum of 1.
- Sub-module chunk_adder: combinational CHUNK-bit adder (a, b, cin -> s, cout), instantiated once.
- The controller holds the FSM, index counter, carry reg, operand regs and result reg.

Test Plan:
- Basic add (defaults): a=0x123, b=0x456, cin=0 accepted at edge k -> res_valid at edge k+4, sum=0x579, cout=0, ovf=0.
- Full carry ripple: a=0xFFF, b=0x001, cin=0 -> sum=0x000, cout=1, ovf=0, with the carry crossing all 4 chunks.
- Signed overflow: a=0x7FF, b=0x001 -> sum=0x800, cout=0, ovf=1. Then a=0x800, b=0x800 -> sum=0x000, cout=1, ovf=1.
- Carry-in only: a=0, b=0, cin=1 -> sum=0x001, cout=0.
- Backpressure and ignore:
  - Hold res_ready=0 for 5 cycles after res_valid while driving start_valid=1 with new operands.
  - Required: sum/cout/res_valid stable, start_ready=0, no capture.
  - Raise res_ready: IDLE next cycle, then the new op is accepted and its result is correct.
- Reset mid-operation: assert rst_n=0 two cycles after accept -> res_valid=0, busy=0, sum=0 immediately. After release, a=0x00A, b=0x005 -> sum=0x00F with normal 4-cycle latency.
